// File: rtl/scale_demux_pkg.sv
// -----------------------------------------------------------------------------
// scale_demux_pkg
// Shared types for the registered 1-to-2 demultiplexer:
//   slot_state_t   - occupancy of one output channel register
//   target_t       - decoded routing target of the current input word
//   decode_target  - maps sel_a to a target; anything not 0/1 is TGT_NONE
// -----------------------------------------------------------------------------
package scale_demux_pkg;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

    typedef enum logic [1:0] {TGT_A, TGT_B, TGT_NONE} target_t;

    // Case equality so an X/Z select never aliases onto a real channel.
    function automatic target_t decode_target(input logic sel);
        if (sel === 1'b1) begin
            return TGT_A;
        end
        if (sel === 1'b0) begin
            return TGT_B;
        end
        return TGT_NONE;
    endfunction

endpackage

// File: rtl/scale_demux_if.sv
// -----------------------------------------------------------------------------
// scale_demux_if
// Bundles the input handshake, both output channel handshakes, the select
// error pulse and the per-channel transfer counters.
//   slave  modport - used by the demux itself
//   master modport - used by the producer/consumer side (e.g. a testbench)
// -----------------------------------------------------------------------------
interface scale_demux_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) ();
    timeunit 1ns;
    timeprecision 100ps;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sel_a;

    logic             out_a_valid;
    logic             out_a_ready;
    logic [WIDTH-1:0] out_a_data;

    logic             out_b_valid;
    logic             out_b_ready;
    logic [WIDTH-1:0] out_b_data;

    logic             sel_err;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport slave (
        input  in_valid, in_data, sel_a, out_a_ready, out_b_ready,
        output in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data,
               sel_err, cnt_a, cnt_b
    );

    modport master (
        output in_valid, in_data, sel_a, out_a_ready, out_b_ready,
        input  in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data,
               sel_err, cnt_a, cnt_b
    );

endinterface

// File: rtl/scale_demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry output register for a single demux channel.
//   clk, rst_   - clock, asynchronous active-low reset
//   i_wr_en     - load i_data this cycle (already qualified by the top)
//   i_data      - word to load
//   i_ready     - downstream consumer accepts the held word
//   o_valid     - slot is FULL
//   o_data      - held word
//   o_wr_ok     - slot can take a word this cycle (empty, or draining)
//   o_cnt       - number of words loaded, wrapping
// -----------------------------------------------------------------------------
module demux_slot
    import scale_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_wr_ok,
    output logic [CNT_W-1:0] o_cnt
);
    timeunit 1ns;
    timeprecision 100ps;

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic             w_drain;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;

    assign w_drain = (r_state == SLOT_FULL) & i_ready;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (i_wr_en) w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (w_drain && !i_wr_en) w_state_nxt = SLOT_EMPTY;
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        o_valid = (r_state == SLOT_FULL);
        // A draining slot can be refilled in the same cycle.
        o_wr_ok = (r_state == SLOT_EMPTY) | i_ready;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_wr_en) begin
            r_data <= i_data;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign o_data = r_data;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/scale_demux.sv
// -----------------------------------------------------------------------------
// scale_demux
// Registered 1-to-2 demultiplexer: steers in_data to channel A (sel_a = 1)
// or channel B (sel_a = 0); each channel is a one-entry valid/ready register.
//   clk, rst_  - clock, asynchronous active-low reset
//   bus        - scale_demux_if.slave: input handshake + in_data + sel_a,
//                channel A/B valid/ready/data, sel_err pulse, cnt_a/cnt_b
// An X/Z select blocks the input (in_ready = 0) and raises sel_err for one
// cycle per offending cycle; no slot or counter changes.
// -----------------------------------------------------------------------------
module scale_demux
    import scale_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_,
    scale_demux_if.slave     bus
);
    timeunit 1ns;
    timeprecision 100ps;

    target_t w_tgt;
    logic    w_ok_a;
    logic    w_ok_b;
    logic    w_in_ready;
    logic    w_wr_a;
    logic    w_wr_b;
    logic    r_sel_err;

    always_comb begin
        w_tgt = decode_target(bus.sel_a);
    end

    always_comb begin
        w_in_ready = 1'b0;
        case (w_tgt)
            TGT_A:   w_in_ready = w_ok_a;
            TGT_B:   w_in_ready = w_ok_b;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign bus.in_ready = w_in_ready;
    assign w_wr_a       = bus.in_valid & w_in_ready & (w_tgt == TGT_A);
    assign w_wr_b       = bus.in_valid & w_in_ready & (w_tgt == TGT_B);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= bus.in_valid & (w_tgt == TGT_NONE);
        end
    end

    assign bus.sel_err = r_sel_err;

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_a (
        .clk     (clk),
        .rst_    (rst_),
        .i_wr_en (w_wr_a),
        .i_data  (bus.in_data),
        .i_ready (bus.out_a_ready),
        .o_valid (bus.out_a_valid),
        .o_data  (bus.out_a_data),
        .o_wr_ok (w_ok_a),
        .o_cnt   (bus.cnt_a)
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot_b (
        .clk     (clk),
        .rst_    (rst_),
        .i_wr_en (w_wr_b),
        .i_data  (bus.in_data),
        .i_ready (bus.out_b_ready),
        .o_valid (bus.out_b_valid),
        .o_data  (bus.out_b_data),
        .o_wr_ok (w_ok_b),
        .o_cnt   (bus.cnt_b)
    );

endmodule

// File: tb/tb_scale_demux.sv
// -----------------------------------------------------------------------------
// tb_scale_demux
// Directed bench for scale_demux. A default-width instance carries the main
// sequence; a CNT_W = 2 instance exercises counter wrap on channel B.
// -----------------------------------------------------------------------------
module tb_scale_demux;
    timeunit 1ns;
    timeprecision 100ps;

    logic clk;
    logic rst_;

    int checks   = 0;
    int failures = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] m_cnt_a;
    logic [7:0] m_cnt_b;

    scale_demux_if #(.WIDTH(8), .CNT_W(8)) bus  ();
    scale_demux_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

    scale_demux #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    scale_demux #(.WIDTH(8), .CNT_W(2)) u_dut_w (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; drives one cycle, checks the
    // combinational in_ready, scores drains/accepts, then checks the
    // registered outputs after the rising edge and returns at the next
    // falling edge.
    task automatic step(input logic v, input logic s, input logic [7:0] d,
                        input logic ra, input logic rb);
        logic       is_a, is_b, exp_rdy, acc, ill;
        logic [7:0] tmp;
        bus.in_valid    = v;
        bus.sel_a       = s;
        bus.in_data     = d;
        bus.out_a_ready = ra;
        bus.out_b_ready = rb;
        #1;
        is_a    = (s === 1'b1);
        is_b    = (s === 1'b0);
        exp_rdy = is_a ? ((qa.size() == 0) || ra) :
                  is_b ? ((qb.size() == 0) || rb) : 1'b0;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        if (qa.size() != 0 && ra) begin
            tmp = qa.pop_front();
            check("drain_a_data", {24'd0, bus.out_a_data}, {24'd0, tmp});
        end
        if (qb.size() != 0 && rb) begin
            tmp = qb.pop_front();
            check("drain_b_data", {24'd0, bus.out_b_data}, {24'd0, tmp});
        end
        acc = v && exp_rdy;
        ill = v && !is_a && !is_b;
        if (acc && is_a) begin
            qa.push_back(d);
            m_cnt_a = m_cnt_a + 8'd1;
        end
        if (acc && is_b) begin
            qb.push_back(d);
            m_cnt_b = m_cnt_b + 8'd1;
        end
        @(posedge clk);
        #1;
        check("out_a_valid", {31'd0, bus.out_a_valid}, {31'd0, (qa.size() != 0)});
        check("out_b_valid", {31'd0, bus.out_b_valid}, {31'd0, (qb.size() != 0)});
        if (qa.size() != 0) check("out_a_data", {24'd0, bus.out_a_data}, {24'd0, qa[0]});
        if (qb.size() != 0) check("out_b_data", {24'd0, bus.out_b_data}, {24'd0, qb[0]});
        check("cnt_a", {24'd0, bus.cnt_a}, {24'd0, m_cnt_a});
        check("cnt_b", {24'd0, bus.cnt_b}, {24'd0, m_cnt_b});
        check("sel_err", {31'd0, bus.sel_err}, {31'd0, ill});
        @(negedge clk);
    endtask

    initial begin : stim
        logic [1:0] wrap_exp [5];
        wrap_exp[0] = 2'd1;
        wrap_exp[1] = 2'd2;
        wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0;
        wrap_exp[4] = 2'd1;

        rst_ = 1'b0;
        bus.in_valid = 1'b0; bus.sel_a = 1'b0; bus.in_data = '0;
        bus.out_a_ready = 1'b0; bus.out_b_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.sel_a = 1'b0; bus2.in_data = '0;
        bus2.out_a_ready = 1'b0; bus2.out_b_ready = 1'b0;
        m_cnt_a = '0;
        m_cnt_b = '0;

        // Reset state
        #3;
        check("rst_a_valid", {31'd0, bus.out_a_valid}, 32'd0);
        check("rst_b_valid", {31'd0, bus.out_b_valid}, 32'd0);
        check("rst_a_data",  {24'd0, bus.out_a_data}, 32'd0);
        check("rst_b_data",  {24'd0, bus.out_b_data}, 32'd0);
        check("rst_cnt_a",   {24'd0, bus.cnt_a}, 32'd0);
        check("rst_cnt_b",   {24'd0, bus.cnt_b}, 32'd0);
        check("rst_sel_err", {31'd0, bus.sel_err}, 32'd0);
        check("rst_w_cnt_b", {30'd0, bus2.cnt_b}, 32'd0);
        @(negedge clk);
        rst_ = 1'b1;

        // Reset mid-transfer: asynchronous clear between edges
        step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        #2;
        rst_ = 1'b0;
        #1;
        check("async_a_valid", {31'd0, bus.out_a_valid}, 32'd0);
        check("async_a_data",  {24'd0, bus.out_a_data}, 32'd0);
        check("async_cnt_a",   {24'd0, bus.cnt_a}, 32'd0);
        qa.delete();
        qb.delete();
        m_cnt_a = '0;
        m_cnt_b = '0;
        @(negedge clk);
        rst_ = 1'b1;

        // Routing
        step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'hC3, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Backpressure isolation
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Simultaneous drain and write on A at full rate
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b1, 1'b0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Alternating select at full rate
        step(1'b1, 1'b1, 8'h21, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b1, 1'b1);
        step(1'b1, 1'b1, 8'h23, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // Illegal select with both channels full and stalled
        step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
        step(1'b1, 1'bx, 8'hEE, 1'b0, 1'b0);
        step(1'b1, 1'bx, 8'hEF, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Counter wrap on the narrow-counter instance
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid    = 1'b1;
            bus2.sel_a       = 1'b0;
            bus2.in_data     = 8'(8'h40 + i);
            bus2.out_b_ready = 1'b1;
            #1;
            check("wrap_in_ready", {31'd0, bus2.in_ready}, 32'd1);
            @(posedge clk);
            #1;
            check("wrap_cnt_b", {30'd0, bus2.cnt_b}, {30'd0, wrap_exp[i]});
            check("wrap_b_data", {24'd0, bus2.out_b_data}, 32'(8'h40 + i));
            @(negedge clk);
        end
        bus2.in_valid = 1'b0;
        check("wrap_cnt_a", {30'd0, bus2.cnt_a}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scale_demux.md
# scale_demux

Registered 1-to-2 demultiplexer: the inverse of the datapath's scalable mux. A single input word is steered to output channel A when `sel_a = 1` or to channel B when `sel_a = 0`. Each channel holds the word in a one-entry output register with a valid/ready handshake. The block sits on the CPU data path where a memory read word is distributed to one of two consumers, for example the instruction register versus the accumulator/ALU operand path. Unknown selects are detected and flagged, never propagated into a register.

## Interface
Parameters:
- `WIDTH`, default 8: data word width.
- `CNT_W`, default 8: width of each per-channel transfer counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  input can be accepted this cycle.
- `in_data`  in  WIDTH  input word.
- `sel_a`  in  1  route select: 1 means channel A, 0 means channel B, X/Z means illegal.
- `out_a_valid` / `out_b_valid`  out  1  channel holds a word.
- `out_a_ready` / `out_b_ready`  in  1  consumer takes the word.
- `out_a_data` / `out_b_data`  out  WIDTH  held word.
- `sel_err`  out  1  one-cycle pulse: `in_valid` was high with a non-0/1 `sel_a`.
- `cnt_a` / `cnt_b`  out  CNT_W  words accepted into each channel, wrapping.

## Operation
- Each channel is a two-state slot, `EMPTY` or `FULL`.
  - `EMPTY` to `FULL` on a write.
  - `FULL` to `EMPTY` on a drain (`out_x_valid & out_x_ready`) with no write.
  - `FULL` stays `FULL` on a simultaneous drain and write.
- `out_x_valid` is 1 exactly when the slot is `FULL`. `out_x_data` is held stable while valid and not drained.
- Target channel: A if `sel_a === 1'b1`, B if `sel_a === 1'b0`, none otherwise.
- `in_ready` = (target slot `EMPTY`) | (target `out_x_ready`). It is combinational from `sel_a`, the slot state and the target's ready.
  - `in_ready` is 0 when the target is none.
- Write occurs on `in_valid & in_ready`: the target slot loads `in_data` and its `cnt_x` increments modulo 2^CNT_W.
- The non-target channel is unaffected by a write. Both channels may drain in the same cycle.
- Illegal select with `in_valid = 1`:
  - no write, and no counter change;
  - `sel_err` = 1 on the following cycle, for one cycle per offending cycle.
- `in_data` is never gated or modified. Data is not checked for X.

## Timing
- Reset (`rst_ = 0`, asynchronous): both slots `EMPTY`, `out_*_valid = 0`, `out_*_data = 0`, `sel_err = 0`, `cnt_a = cnt_b = 0`. Held words are discarded. The outputs reflect reset immediately, without waiting for `clk`.
- Reset release is synchronous in effect: the first write is possible at the first rising edge with `rst_ = 1`.
- Latency: a word accepted at edge N is presented with `out_x_valid = 1` after edge N (1 cycle).
- Throughput: 1 word per cycle per channel while the consumer holds `out_x_ready = 1`. Alternating `sel_a` at full rate is allowed.
- Backpressure: with a channel `FULL` and its ready at 0, any input targeting it stalls (`in_ready = 0`). Input targeting the other channel still flows.
- Counter wrap: `2^CNT_W - 1` to 0 with no flag.
- `sel_err` is registered. It is cleared on the next edge unless the illegal condition repeats.

## Structure
- Package `scale_demux_pkg`:
  - `typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t`;
  - `typedef enum logic [1:0] {TGT_A, TGT_B, TGT_NONE} target_t`.
- Sub-module `demux_slot #(WIDTH, CNT_W)` is instantiated twice. It contains:
  - one slot's state register, data register and counter;
  - its valid/ready logic, and its write-enable input.
- The top level contains target decode (using `===` case equality so X maps to `TGT_NONE`), the `in_ready` mux, and the `sel_err` register.
- Declare `timeunit 1ns; timeprecision 100ps;` as in the other datapath blocks.

## Test plan
- Reset mid-transfer: fill A with `8'hA5`, assert `rst_ = 0` between edges → `out_a_valid = 0`, `out_a_data = 8'h00`, `cnt_a = 0` immediately, without waiting for `clk`.
- Routing: send `8'h3C` with `sel_a = 1`, then `8'hC3` with `sel_a = 0`, both readies at 1 → `out_a_data = 8'h3C` one cycle after its accept and `out_b_data = 8'hC3` the next cycle; `cnt_a = cnt_b = 1`.
- Backpressure isolation: `out_a_ready = 0` with A `FULL` → `in_ready = 0` for `sel_a = 1`. Switch to `sel_a = 0` → word `8'h11` reaches B while A still holds its word unchanged.
- Simultaneous drain and write on A with ready held at 1 for 4 cycles, words `8'h01` to `8'h04` → one word per cycle, `out_a_valid` stays 1, `cnt_a = 4`.
- Illegal select: `in_valid = 1`, `sel_a = 1'bx` for 2 cycles → `in_ready = 0`, no slot change, `sel_err` high for the 2 following cycles, counters unchanged.
- Counter wrap with `CNT_W = 2`: 5 accepts to B → `cnt_b` sequence 1, 2, 3, 0, 1.
